// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target memory block.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_ACK_DEV,
    S_WORD_ADDR,
    S_ACK_WORD,
    S_WR_DATA,
    S_ACK_WR,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } i2c_tgt_state_t;

  localparam logic        I2C_RW_READ = 1'b1;
  localparam logic        I2C_ACK     = 1'b0;
  localparam logic        I2C_NACK    = 1'b1;
  localparam int unsigned MEM_DEPTH   = 128;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one I2C line with rise/fall detection on the synchronized value.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the idle-high bus level so leaving reset never produces a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a 128-byte memory: address match, word-address write bursts and
// pointer-based read bursts with auto-increment.
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_done,
  output logic [6:0] ptr
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (scl_i),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (sda_i),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  i2c_tgt_state_t r_state;
  logic [3:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_phase;
  logic           r_rw;
  logic           r_sda_oe;
  logic           r_busy;
  logic           r_wr_done;
  logic [6:0]     r_ptr;
  logic [7:0]     r_mem [MEM_DEPTH];

  logic       w_start, w_stop, w_last_bit, w_mem_we;
  logic [7:0] w_byte, w_rd_next;
  logic [6:0] w_ptr_inc;

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last_bit = w_scl_rise && (r_bit_cnt == 4'd7);
  assign w_ptr_inc  = r_ptr + 7'd1;
  assign w_rd_next  = r_mem[w_ptr_inc];
  assign w_mem_we   = (r_state == S_WR_DATA) && w_last_bit && !w_start && !w_stop;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_phase   <= 1'b0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
      r_ptr     <= 7'd0;
    end else begin
      r_wr_done <= 1'b0;
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_DEV_ADDR;
        r_bit_cnt <= 4'd0;
        r_phase   <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_DEV_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  r_state <= S_ACK_DEV;
                  r_busy  <= 1'b1;
                  r_rw    <= w_byte[0];
                  r_phase <= 1'b0;
                end else begin
                  r_state <= S_WAIT_STOP;
                end
              end
            end
          end
          S_WORD_ADDR, S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_phase <= 1'b0;
                if (r_state == S_WORD_ADDR) begin
                  r_ptr   <= w_byte[6:0];
                  r_state <= S_ACK_WORD;
                end else begin
                  r_ptr     <= w_ptr_inc;
                  r_wr_done <= 1'b1;
                  r_state   <= S_ACK_WR;
                end
              end
            end
          end
          // Phase 0: pull SDA low at the first fall; phase 1: end the ACK at the next fall.
          S_ACK_DEV, S_ACK_WORD, S_ACK_WR: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_bit_cnt <= 4'd0;
                if (r_state == S_ACK_DEV && r_rw == I2C_RW_READ) begin
                  r_shift  <= r_mem[r_ptr];
                  r_sda_oe <= ~r_mem[r_ptr][7];
                  r_state  <= S_RD_DATA;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == S_ACK_DEV) ? S_WORD_ADDR : S_WR_DATA;
                end
              end
            end
          end
          S_RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_phase  <= 1'b0;
                r_state  <= S_RD_ACK;
              end else begin
                r_sda_oe <= ~r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
              end
            end
          end
          // The next byte is prefetched at the ACK sample and driven at the following fall.
          S_RD_ACK: begin
            if (w_scl_rise) begin
              r_ptr <= w_ptr_inc;
              if (w_sda == I2C_ACK) begin
                r_shift <= w_rd_next;
                r_phase <= 1'b1;
              end else begin
                r_state <= S_WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end else if (w_scl_fall && r_phase) begin
              r_sda_oe  <= ~r_shift[7];
              r_bit_cnt <= 4'd0;
              r_phase   <= 1'b0;
              r_state   <= S_RD_DATA;
            end
          end
          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe  = r_sda_oe;
  assign busy    = r_busy;
  assign wr_done = r_wr_done;
  assign ptr     = r_ptr;

endmodule
